// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The entry type is used both for buffered instructions and for in-flight request tags.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 64;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(PC_STEP - 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with push, pop, clear, occupancy count and full/empty flags.
// Push while full is honoured only together with a pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fetch_entry_t  push_data,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) begin
                rptr <= next_ptr(rptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Pipeline front end: owns the PC, issues credit-limited in-order fetches and queues results for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects raise fetch_fault and halt fetching.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [XLEN-1:0]    id_pc,
    output logic               fetch_fault
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, redirect_target;
    logic [CW-1:0]   discard_cnt, q_cnt, tag_cnt;
    logic            q_full, q_empty, tag_full, tag_empty;
    logic            misalign, credit_ok, req_accept, rsp_pop, q_push, q_pop;
    fetch_entry_t    q_head, tag_head, tag_entry, rsp_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
    assign misalign        = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_target = align_word(redirect_pc);
    assign misalign        = 1'b0;
`endif

    // Outstanding fetches are exactly the tag queue occupancy, so credit covers both queues.
    assign credit_ok  = !q_full && !tag_full &&
                        (((CW+1)'(q_cnt) + (CW+1)'(tag_cnt)) < (CW+1)'(QUEUE_DEPTH));
    assign req_accept = imem_req_valid && imem_req_ready;
    assign rsp_pop    = imem_rsp_valid && !tag_empty;
    assign q_push     = rsp_pop && (discard_cnt == '0) && !redirect_valid;
    assign id_valid   = !q_empty && !redirect_valid;
    assign q_pop      = id_valid && id_ready;

    assign imem_req_addr = pc;
    assign id_pc         = q_head.pc;
    assign id_instr      = q_head.instr;
    assign tag_entry     = '{pc: pc, instr: '0};

    always_comb begin
        rsp_entry       = tag_head;
        rsp_entry.instr = imem_rsp_data;
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_instr_queue (
        .clk       (clk),
        .rst_n     (reset),
        .push      (q_push),
        .pop       (q_pop),
        .clear     (redirect_valid),
        .push_data (rsp_entry),
        .head      (q_head),
        .count     (q_cnt),
        .full      (q_full),
        .empty     (q_empty)
    );

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_tag_queue (
        .clk       (clk),
        .rst_n     (reset),
        .push      (req_accept),
        .pop       (rsp_pop),
        .clear     (1'b0),
        .push_data (tag_entry),
        .head      (tag_head),
        .count     (tag_cnt),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  imem_req_valid = credit_ok;
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: if (redirect_valid && !misalign) state_next = ST_RUN;
`endif
            default: state_next = ST_BOOT;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign) state_next = ST_HALT;
`endif
    end

    // Responses still owed for pre-redirect requests are counted here and dropped on arrival.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            discard_cnt <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc          <= redirect_target;
                discard_cnt <= tag_cnt + CW'(req_accept) - CW'(rsp_pop);
            end else begin
                if (req_accept) pc <= pc + XLEN'(PC_STEP);
                if (rsp_pop && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= misalign;
    end

    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios then random traffic against a queue-level model.
// Expectations follow FETCH_MISALIGN_TRAP_EN when the bench is built with it.
module tb_instruction_fetch_stage;
    import fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          DEPTH  = 2;

    logic        clk, reset;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        fetch_fault;

    instruction_fetch_stage #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          cyc;
        bit          stale;
    } flight_t;

    flight_t      inflight[$];
    fetch_entry_t buffered[$];
    logic [63:0]  fpc;
    bit           booting, halted, fault_exp;
    int           cyc, n_pass, n_total;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic modelReset();
        inflight.delete();
        buffered.delete();
        fpc       = RST_PC;
        booting   = 1'b1;
        halted    = 1'b0;
        fault_exp = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic applyStimulus(input bit redir, input logic [63:0] tgt, input bit rdy,
                                 input bit dec_rdy, input bit rsp_en);
        bit      rsp, exp_req, exp_idv, accept;
        flight_t f;
        @(negedge clk);
        cyc++;
        rsp            = rsp_en && (inflight.size() > 0) && (inflight[0].cyc < cyc);
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_req_ready = rdy;
        id_ready       = dec_rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(inflight[0].addr) : $urandom();
        #1;
        exp_req = !booting && !halted && ((buffered.size() + inflight.size()) < DEPTH);
        exp_idv = (buffered.size() > 0) && !redir;
        checkOutput("req_valid", {63'b0, imem_req_valid}, {63'b0, exp_req});
        if (exp_req) checkOutput("req_addr", imem_req_addr, fpc);
        checkOutput("id_valid", {63'b0, id_valid}, {63'b0, exp_idv});
        if (exp_idv) begin
            checkOutput("id_pc", id_pc, buffered[0].pc);
            checkOutput("id_instr", {32'b0, id_instr}, {32'b0, buffered[0].instr});
        end
        checkOutput("fetch_fault", {63'b0, fetch_fault}, {63'b0, fault_exp});

        accept = exp_req && rdy;
        if (exp_idv && dec_rdy) void'(buffered.pop_front());
        if (rsp) begin
            f = inflight.pop_front();
            if (!f.stale && !redir) buffered.push_back('{pc: f.addr, instr: instr_of(f.addr)});
        end
        if (accept) inflight.push_back('{addr: fpc, cyc: cyc, stale: redir});
        fault_exp = 1'b0;
        if (redir) begin
            buffered.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            halted    = (tgt[1:0] != 2'b00);
            fault_exp = halted;
            fpc       = tgt;
`else
            fpc = tgt & ~64'h3;
`endif
        end else if (accept) begin
            fpc = fpc + 64'd4;
        end
        booting = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
        checkOutput("rst_req_addr", imem_req_addr, RST_PC);
        checkOutput("rst_id_valid", {63'b0, id_valid}, 64'd0);
        checkOutput("rst_id_instr", {32'b0, id_instr}, 64'd0);
        checkOutput("rst_id_pc", id_pc, 64'd0);
        checkOutput("rst_fetch_fault", {63'b0, fetch_fault}, 64'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1 checkResetState();
        @(posedge clk); #2 reset = 1'b1;

        // Decode stalled: two fetches fill the queue and the head stays at RESET_PC.
        repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        repeat (8)  applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Redirect with two fetches outstanding.
        repeat (3)  applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h2000, 1'b1, 1'b1, 1'b0);
        repeat (8)  applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Redirect colliding with a response while decode is ready.
        repeat (2)  applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h2400, 1'b1, 1'b1, 1'b1);
        repeat (6)  applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Memory back-pressure holds the request address.
        repeat (5)  applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        repeat (6)  applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Misaligned redirect, then an aligned one.
        applyStimulus(1'b1, 64'h2002, 1'b1, 1'b1, 1'b1);
        repeat (6)  applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h3000, 1'b1, 1'b1, 1'b1);
        repeat (6)  applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // PC wrap-around at the top of the address space.
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset in the middle of traffic.
        #1 reset = 1'b0;
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        #1 checkResetState();
        modelReset();
        @(posedge clk); #2 reset = 1'b1;
        repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom % 20) == 0, {$urandom(), $urandom()},
                          ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
